game_board: RTL
===============

# game_board

Authoritative tic-tac-toe board register and move arbiter. It accepts move coordinates from the human input path and from the `cpu` move generator, and rejects illegal moves. Legal moves update the 9-cell board, and the block detects a win or a draw. Its board output is the board-state input of the `cpu` move generator and of the VGA renderer.

## Interface
- `FIRST_PLAYER`, default 0: player who moves first after reset or `new_game` (0 = X/human, 1 = O/cpu).
- `clock`  in  1: single system clock, rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state.
- `new_game`  in  1: synchronous clear of game state; any FSM state.
- `move_valid`  in  1: move request present.
- `move_coord`  in  4: cell index 0..8, row-major; 9..15 illegal.
- `move_player`  in  1: requesting player (0 = X, 1 = O).
- `move_ready`  out  1: block can accept a move.
- `move_ack`  out  1: one-cycle pulse, move applied.
- `move_reject`  out  1: one-cycle pulse, move refused.
- `board_cells`  out  18: cell i at bits [2i+1:2i]; 00 empty, 01 X, 10 O; 11 is never written.
- `turn`  out  1: player expected to move next.
- `move_count`  out  4: applied moves, 0..9.
- `winner`  out  2: 00 none, 01 X, 10 O.
- `draw`  out  1: board full with no winner.
- `game_over`  out  1: win or draw.

## Operation
- FSM states:
  - WAIT: `move_ready`=1.
  - CHECK: latched move evaluated.
  - EVAL: win/draw computed.
  - OVER: game finished.
- WAIT→CHECK on `move_valid && move_ready`; `move_coord` and `move_player` are latched.
- CHECK legality: coord ≤ 8, cell empty, and `move_player == turn` (turn check gated by macro, see Configuration).
  - Legal: write the cell (01 for X, 10 O), increment `move_count`, pulse `move_ack`, go to EVAL.
  - Illegal: pulse `move_reject`, return to WAIT; board unchanged.
- EVAL: check 8 lines (3 rows, 3 cols, 2 diagonals) on the updated board.
  - Win: set `winner` to the mover's code, `game_over`=1, go to OVER.
  - Else if `move_count`==9: `draw`=1, `game_over`=1, go to OVER.
  - Else toggle `turn`, go to WAIT.
- OVER: `move_ready`=0; `move_valid` ignored; exit only via `new_game` or `reset`.
- `new_game` (any state) next edge:
  - board all 00, `move_count`=0, `winner`=00, `draw`=0, `game_over`=0;
  - `turn`=`FIRST_PLAYER`; state WAIT;
  - `move_ack`/`move_reject` forced 0.
- `new_game` has priority over a same-cycle handshake; that move is dropped without ack/reject.

## Timing
- Reset values:
  - board 0, `turn`=`FIRST_PLAYER`, `move_count`=0, `winner`=00;
  - `draw`=0, `game_over`=0, `move_ack`=0, `move_reject`=0;
  - state WAIT, so `move_ready`=1.
- `move_ready` decodes the registered state: high only in WAIT.
- Handshake at edge E0 → `move_ack`/`move_reject` and new `board_cells` visible after E1 → `winner`/`draw`/`game_over`/`turn` valid after E2.
- Accept-to-ready throughput: 3 cycles per legal move, 2 per rejected move.
- `reset` asserted mid-CHECK/EVAL: immediate asynchronous clear; the pending move is lost and no pulse is produced.
- All outputs are registered except `move_ready`.

## Configuration
- `GAME_BOARD_TURN_CHECK_EN` defined: a move whose `move_player` ≠ `turn` is rejected.
- Undefined: `move_player` is not compared against `turn`; the cell is written with the `move_player` code; `turn` still toggles after each legal non-final move.

## Structure
- Shared package `tictactoe_pkg`:
  - cell encoding constants (EMPTY, X, O);
  - FSM state enum;
  - 8-entry win-line table of cell index triples;
  - `CELLS`=9.
- Sub-module `win_detect`: combinational; input `board_cells` [18]; outputs `x_wins`, `o_wins`. Reused by the VGA highlight logic.

## Test plan
- Reset, then X→4, O→0, X→2, O→8, X→6 (all with correct players) → five acks; after the last move's EVAL `winner`=01, `game_over`=1, `move_ready`=0.
- X→4 then O→4 → second move `move_reject`=1 for one cycle; cell 4 stays 01; `move_count`=1; `turn` stays 1.
- `move_coord`=9 and `move_coord`=15 → reject; board unchanged.
- With `GAME_BOARD_TURN_CHECK_EN`, first move with `move_player`=1 → reject. Without the macro → ack, cell written 10, `turn` toggles to 1.
- Nine alternating moves X→0,O→1,X→2,O→4,X→3,O→5,X→7,O→6,X→8 (no line) → `draw`=1, `winner`=00, `move_count`=9.
- Two cases:
  - `new_game` in the same cycle as a handshake → next cycle board 0, no ack/reject, WAIT.
  - `reset` pulse during CHECK → all outputs at reset values, no ack/reject pulse.

Source files
------------

// File: rtl/tictactoe_pkg.sv
// rtl/tictactoe_pkg.sv - shared tic-tac-toe encodings, FSM states and win-line table
package tictactoe_pkg;

  localparam int CELLS = 9;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_X     = 2'b01;
  localparam logic [1:0] CELL_O     = 2'b10;

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_CHECK = 2'd1,
    ST_EVAL  = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  // Eight winning lines as cell index triples; entry 0 is the rightmost group.
  // 0..2: rows, 3..5: columns, 6..7: diagonals.
  localparam logic [7:0][2:0][3:0] WIN_LINES = {
    {4'd2, 4'd4, 4'd6},
    {4'd0, 4'd4, 4'd8},
    {4'd2, 4'd5, 4'd8},
    {4'd1, 4'd4, 4'd7},
    {4'd0, 4'd3, 4'd6},
    {4'd6, 4'd7, 4'd8},
    {4'd3, 4'd4, 4'd5},
    {4'd0, 4'd1, 4'd2}
  };

  // Two-bit code of cell idx in the flat board vector.
  function automatic logic [1:0] cell_at(input logic [17:0] board, input logic [3:0] idx);
    return board[{idx, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/win_detect.sv
// rtl/win_detect.sv - combinational three-in-a-row detector for both players
module win_detect
  import tictactoe_pkg::*;
(
  input  logic [17:0] board_cells,
  output logic        x_wins,
  output logic        o_wins
);

  // Scan every win line for three matching marks of either player.
  always_comb begin
    x_wins = 1'b0;
    o_wins = 1'b0;
    for (int l = 0; l < 8; l++) begin
      x_wins = x_wins |
               ((cell_at(board_cells, WIN_LINES[l[2:0]][0]) == CELL_X) &&
                (cell_at(board_cells, WIN_LINES[l[2:0]][1]) == CELL_X) &&
                (cell_at(board_cells, WIN_LINES[l[2:0]][2]) == CELL_X));
      o_wins = o_wins |
               ((cell_at(board_cells, WIN_LINES[l[2:0]][0]) == CELL_O) &&
                (cell_at(board_cells, WIN_LINES[l[2:0]][1]) == CELL_O) &&
                (cell_at(board_cells, WIN_LINES[l[2:0]][2]) == CELL_O));
    end
  end

endmodule

// File: rtl/game_board.sv
// rtl/game_board.sv - tic-tac-toe board register and move arbiter; optional turn check via GAME_BOARD_TURN_CHECK_EN
module game_board
  import tictactoe_pkg::*;
#(
  parameter logic FIRST_PLAYER = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        new_game,
  input  logic        move_valid,
  input  logic [3:0]  move_coord,
  input  logic        move_player,
  output logic        move_ready,
  output logic        move_ack,
  output logic        move_reject,
  output logic [17:0] board_cells,
  output logic        turn,
  output logic [3:0]  move_count,
  output logic [1:0]  winner,
  output logic        draw,
  output logic        game_over
);

  state_t      state_q, state_d;
  logic [17:0] board_q, board_d;
  logic        turn_q, turn_d;
  logic [3:0]  count_q, count_d;
  logic [3:0]  coord_q, coord_d;
  logic        player_q, player_d;
  logic [1:0]  winner_q, winner_d;
  logic        draw_q, draw_d;
  logic        over_q, over_d;
  logic        ack_q, ack_d;
  logic        rej_q, rej_d;

  logic        x_wins, o_wins;
  logic        turn_ok, coord_ok, legal;
  logic [1:0]  cell_now, mover_code;

  win_detect u_win_detect (
    .board_cells (board_q),
    .x_wins      (x_wins),
    .o_wins      (o_wins)
  );

`ifdef GAME_BOARD_TURN_CHECK_EN
  assign turn_ok = (player_q == turn_q);
`else
  assign turn_ok = 1'b1;
`endif

  // Out-of-range coordinates never index the board; they are rejected on coord_ok alone.
  assign coord_ok   = (coord_q < 4'(CELLS));
  assign cell_now   = cell_at(board_q, coord_ok ? coord_q : 4'd0);
  assign mover_code = player_q ? CELL_O : CELL_X;
  assign legal      = coord_ok && (cell_now == CELL_EMPTY) && turn_ok;

  // Next-state logic: new_game overrides everything, including a same-cycle handshake.
  always_comb begin
    state_d  = state_q;
    board_d  = board_q;
    turn_d   = turn_q;
    count_d  = count_q;
    coord_d  = coord_q;
    player_d = player_q;
    winner_d = winner_q;
    draw_d   = draw_q;
    over_d   = over_q;
    ack_d    = 1'b0;
    rej_d    = 1'b0;
    if (new_game) begin
      state_d  = ST_WAIT;
      board_d  = '0;
      turn_d   = FIRST_PLAYER;
      count_d  = '0;
      winner_d = CELL_EMPTY;
      draw_d   = 1'b0;
      over_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_WAIT: begin
          if (move_valid) begin
            coord_d  = move_coord;
            player_d = move_player;
            state_d  = ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (legal) begin
            board_d[{coord_q, 1'b0} +: 2] = mover_code;
            count_d = count_q + 4'd1;
            ack_d   = 1'b1;
            state_d = ST_EVAL;
          end else begin
            rej_d   = 1'b1;
            state_d = ST_WAIT;
          end
        end
        ST_EVAL: begin
          if (x_wins || o_wins) begin
            winner_d = mover_code;
            over_d   = 1'b1;
            state_d  = ST_OVER;
          end else if (count_q == 4'(CELLS)) begin
            draw_d  = 1'b1;
            over_d  = 1'b1;
            state_d = ST_OVER;
          end else begin
            turn_d  = ~turn_q;
            state_d = ST_WAIT;
          end
        end
        ST_OVER: state_d = ST_OVER;
        default: state_d = ST_WAIT;
      endcase
    end
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_WAIT;
      board_q  <= '0;
      turn_q   <= FIRST_PLAYER;
      count_q  <= '0;
      coord_q  <= '0;
      player_q <= 1'b0;
      winner_q <= CELL_EMPTY;
      draw_q   <= 1'b0;
      over_q   <= 1'b0;
      ack_q    <= 1'b0;
      rej_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      board_q  <= board_d;
      turn_q   <= turn_d;
      count_q  <= count_d;
      coord_q  <= coord_d;
      player_q <= player_d;
      winner_q <= winner_d;
      draw_q   <= draw_d;
      over_q   <= over_d;
      ack_q    <= ack_d;
      rej_q    <= rej_d;
    end
  end

  assign move_ready  = (state_q == ST_WAIT);
  assign move_ack    = ack_q;
  assign move_reject = rej_q;
  assign board_cells = board_q;
  assign turn        = turn_q;
  assign move_count  = count_q;
  assign winner      = winner_q;
  assign draw        = draw_q;
  assign game_over   = over_q;

endmodule
